// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a FIFO and serializes them as UART 8N1 frames
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic [7:0] frames_sent
);
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  state_t state, state_n;
  logic [15:0] timer, timer_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n, frames_n;
  logic tx_n, bit_end;
  assign bit_end = timer == LAST;
  assign busy = state != IDLE;
  assign fifo_rd_en = rst_n && state == IDLE && enable && !fifo_empty;
  // state and datapath registers; reset abandons any frame in flight
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      idx <= '0;
      shift <= '0;
      tx <= 1'b1;
      frames_sent <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      idx <= idx_n;
      shift <= shift_n;
      tx <= tx_n;
      frames_sent <= frames_n;
    end
  // next-state: bit timer runs only while a symbol is on the line
  always_comb begin
    state_n = state;
    idx_n = idx;
    shift_n = shift;
    tx_n = tx;
    frames_n = frames_sent;
    timer_n = (state inside {START, DATA, STOP} && !bit_end) ? timer + 16'd1 : '0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        state_n = fifo_rd_en ? LOAD : IDLE;
      end
      LOAD: begin
        shift_n = fifo_data;
        tx_n = 1'b0;
        state_n = START;
      end
      START:
        if (bit_end) begin
          idx_n = '0;
          tx_n = shift[0];
          state_n = DATA;
        end
      DATA:
        if (bit_end) begin
          if (idx == 3'd7) begin
            tx_n = 1'b1;
            state_n = STOP;
          end else begin
            shift_n = shift >> 1;
            idx_n = idx + 3'd1;
            tx_n = shift[1];
          end
        end
      STOP:
        if (bit_end) begin
          frames_n = frames_sent + 8'd1;
          state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: cycle-level timing model plus directed frame vectors
module tb_fifo_uart_tx;
  localparam int CPB = 4;
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, force_empty = 1'b0;
  logic [7:0] fifo_data = '0;
  logic fifo_empty, fifo_rd_en, tx, busy;
  logic [7:0] frames_sent;
  logic [7:0] mem [0:1023];
  int wr_ptr = 0, rd_ptr = 0;
  int checks = 0, errors = 0, c = 0, ft = -1, cnt = 0;
  logic [7:0] fb = '0;
  logic s_tx, s_rd, s_busy;
  logic [7:0] s_fs;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;
  assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

  // FIFO with registered output, one-cycle read latency
  always @(posedge clk)
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= mem[rd_ptr[9:0]];
      rd_ptr <= rd_ptr + 1;
    end

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s cycle %0d got %0h expected %0h", n, c, act, exp);
    end
  endtask

  // one clock cycle: compare against the timing model at negedge, then advance
  task automatic tick();
    logic e_busy, e_tx, e_rd;
    int o;
    @(negedge clk);
    c++;
    e_busy = ft >= 0 && c >= ft + 1 && c <= ft + 1 + 10 * CPB;
    o = c - ft - 2;
    e_tx = 1'b1;
    if (ft >= 0 && o >= 0 && o < 10 * CPB)
      e_tx = (o < CPB) ? 1'b0 : (o >= 9 * CPB) ? 1'b1 : fb[o / CPB - 1];
    e_rd = rst_n && !e_busy && enable && !fifo_empty;
    s_tx = tx; s_rd = fifo_rd_en; s_busy = busy; s_fs = frames_sent;
    chk("tx", 16'(tx), 16'(e_tx));
    chk("rd_en", 16'(fifo_rd_en), 16'(e_rd));
    chk("busy", 16'(busy), 16'(e_busy));
    chk("frames", 16'(frames_sent), 16'(cnt));
    if (!rst_n) begin
      ft = -1;
      cnt = 0;
    end else begin
      if (ft >= 0 && c == ft + 1 + 10 * CPB) cnt = (cnt + 1) % 256;
      if (e_rd) begin
        ft = c;
        fb = mem[rd_ptr[9:0]];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[9:0]] = b;
    wr_ptr++;
  endtask

  task automatic wait_pop(output int t);
    bit ok = 0;
    t = -1;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      ok = s_rd;
    end
    t = c;
    chk("pop_seen", 16'(ok), 16'd1);
  endtask

  task automatic wait_idle(input int bound);
    bit ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      tick();
      ok = !s_busy && !s_rd && rd_ptr == wr_ptr;
    end
    chk("idle_seen", 16'(ok), 16'd1);
  endtask

  initial begin
    vec_t tbl [4];
    int t1, t2, fs0, rp0;
    bit ok;
    tbl[0] = '{8'hA5, 10'b1101001010};
    tbl[1] = '{8'h00, 10'b1000000000};
    tbl[2] = '{8'hFF, 10'b1111111110};
    tbl[3] = '{8'h55, 10'b1010101010};
    enable = 1'b1;
    push(8'hA5);
    repeat (3) begin
      tick();
      chk("rst_rd", 16'(s_rd), 16'd0);
      chk("rst_tx", 16'(s_tx), 16'd1);
      chk("rst_fs", 16'(s_fs), 16'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) push(tbl[i].data);
      wait_pop(t1);
      for (int k = 0; k < 10; k++) begin
        repeat (k == 0 ? 2 + CPB / 2 : CPB) tick();
        chk($sformatf("vec%0d_sym%0d", i, k), 16'(s_tx), 16'(tbl[i].frame[k]));
      end
      wait_idle(200);
      chk("vec_frames", 16'(s_fs), 16'(i + 1));
    end
    fs0 = cnt;
    push(8'h00);
    push(8'hFF);
    wait_pop(t1);
    wait_pop(t2);
    chk("b2b_spacing", 16'(t2 - t1), 16'(10 * CPB + 2));
    wait_idle(300);
    chk("b2b_frames", 16'(s_fs), 16'((fs0 + 2) % 256));
    force_empty = 1'b1;
    push(8'h11);
    repeat (100) tick();
    force_empty = 1'b0;
    enable = 1'b0;
    repeat (100) tick();
    chk("gate_no_pop", 16'(rd_ptr), 16'(wr_ptr - 1));
    enable = 1'b1;
    wait_idle(300);
    push(8'h3C);
    wait_pop(t1);
    repeat (2 + 3 * CPB) tick();
    enable = 1'b0;
    push(8'h22);
    repeat (10 * CPB + 20) tick();
    chk("drop_en_no_pop", 16'(rd_ptr), 16'(wr_ptr - 1));
    enable = 1'b1;
    wait_idle(300);
    push(8'h96);
    push(8'h5A);
    wait_pop(t1);
    repeat (2 + 4 * CPB) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_tx", 16'(s_tx), 16'd1);
    chk("midrst_fs", 16'(s_fs), 16'd0);
    chk("midrst_busy", 16'(s_busy), 16'd0);
    wait_idle(300);
    chk("midrst_next", 16'(s_fs), 16'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) push(8'h55);
    rp0 = rd_ptr;
    ok = 0;
    for (int i = 0; i < 12000 && !ok; i++) begin
      tick();
      ok = rd_ptr == wr_ptr;
    end
    chk("wrap_last_pop", 16'(ok), 16'd1);
    chk("wrap_pops", 16'(rd_ptr - rp0), 16'd256);
    chk("wrap_255", 16'(s_fs), 16'd255);
    wait_idle(200);
    chk("wrap_0", 16'(s_fs), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
